// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared constants, state encoding and mstatus helpers for the
//               machine-mode trap sequencer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   // System instruction encodings
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   // mstatus bit positions
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // Synchronous exception causes
   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MEPC    = 3'd1,
      S_MCAUSE  = 3'd2,
      S_MSTATUS = 3'd3,
      S_MRET    = 3'd4,
      S_JUMP    = 3'd5
   } trap_state_t;

   // Zero-extend a 12-bit CSR address onto the 32-bit CSR address bus.
   function automatic logic [31:0] csr_addr(input logic [11:0] a);
      return {20'd0, a};
   endfunction

   // Trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [31:0] mstatus_enter(input logic [31:0] m);
      logic [31:0] r;
      r               = m;
      r[MSTATUS_MPIE] = m[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   // Trap return: MIE takes MPIE, MPIE is set.
   function automatic logic [31:0] mstatus_return(input logic [31:0] m);
      logic [31:0] r;
      r               = m;
      r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_irq_sync
// Description : N-flop synchroniser for an asynchronous level input.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset (clears the chain)
//               d     - asynchronous input
//               q     - synchronised output
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl_irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_ff;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_ff[i] <= 1'b0;
         end else begin
            sync_ff[i] <= (i == 0) ? d : sync_ff[(i == 0) ? 0 : i - 1];
         end
      end
   end

   assign q = sync_ff[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode trap sequencer. Detects ECALL/EBREAK/MRET in ID
//               or an enabled external interrupt, stalls the pipeline, writes
//               mepc/mcause/mstatus through a dedicated CSR port and redirects
//               the PC to mtvec (entry) or mepc (return).
// Ports       : clk_i, rst_n_i         - clock, async active-low reset
//               inst_i, inst_addr_i    - instruction in ID and its address
//               jump_flag_i/addr_i     - EX-stage redirect in flight
//               irq_i                  - async level-sensitive interrupt
//               mstatus_i/mepc_i/mtvec_i - current CSR values
//               hold_o                 - pipeline stall
//               csr_wen_o/waddr_o/wdata_o - CSR write port
//               int_assert_o/int_addr_o   - one-cycle PC redirect
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int          IRQ_SYNC_STAGES = 2,
   parameter logic [31:0] IRQ_CAUSE       = 32'h8000_000B
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        irq_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mepc_i,
   input  logic [31:0] mtvec_i,
   output logic        hold_o,
   output logic        csr_wen_o,
   output logic [31:0] csr_waddr_o,
   output logic [31:0] csr_wdata_o,
   output logic        int_assert_o,
   output logic [31:0] int_addr_o
);

   trap_state_t state, state_nxt;
   logic        irq_s;
   logic [31:0] epc_q, cause_q, mstatus_q;
   logic [31:0] epc_nxt, cause_nxt;
   logic        mret_q;       // remembers whether S_JUMP returns or enters
   logic        latch_trap;   // capture epc/cause in the detection cycle
   logic        latch_mst;    // capture mstatus in the detection cycle
   logic        is_mret;
   logic        unused_mtvec_mode;

   // Vectored mode is not supported; the mode bits are dropped.
   assign unused_mtvec_mode = ^mtvec_i[1:0];

   trap_ctrl_irq_sync #(
      .STAGES (IRQ_SYNC_STAGES)
   ) u_irq_sync (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .d     (irq_i),
      .q     (irq_s)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= S_IDLE;
         epc_q     <= 32'd0;
         cause_q   <= 32'd0;
         mstatus_q <= 32'd0;
         mret_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (latch_trap) begin
            epc_q   <= epc_nxt;
            cause_q <= cause_nxt;
         end
         if (latch_mst) begin
            mstatus_q <= mstatus_i;
            mret_q    <= is_mret;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_o       = 1'b0;
      csr_wen_o    = 1'b0;
      csr_waddr_o  = 32'd0;
      csr_wdata_o  = 32'd0;
      int_assert_o = 1'b0;
      int_addr_o   = 32'd0;
      latch_trap   = 1'b0;
      latch_mst    = 1'b0;
      is_mret      = 1'b0;
      epc_nxt      = inst_addr_i;
      cause_nxt    = 32'd0;

      unique case (state)
         S_IDLE: begin
            // Synchronous events are checked first so they always beat an
            // interrupt in the same cycle; a blocked irq remains pending on
            // the level-sensitive line.
            if (inst_i == INST_ECALL) begin
               hold_o     = 1'b1;
               latch_trap = 1'b1;
               latch_mst  = 1'b1;
               cause_nxt  = CAUSE_ECALL;
               state_nxt  = S_MEPC;
            end else if (inst_i == INST_EBREAK) begin
               hold_o     = 1'b1;
               latch_trap = 1'b1;
               latch_mst  = 1'b1;
               cause_nxt  = CAUSE_EBREAK;
               state_nxt  = S_MEPC;
            end else if (inst_i == INST_MRET) begin
               hold_o    = 1'b1;
               latch_mst = 1'b1;
               is_mret   = 1'b1;
               state_nxt = S_MRET;
            end else if (irq_s && mstatus_i[MSTATUS_MIE]) begin
               hold_o     = 1'b1;
               latch_trap = 1'b1;
               latch_mst  = 1'b1;
               cause_nxt  = IRQ_CAUSE;
               // A taken branch in EX means the ID instruction is on the
               // wrong path; resume at the branch target instead.
               epc_nxt    = jump_flag_i ? jump_addr_i : inst_addr_i;
               state_nxt  = S_MEPC;
            end
         end
         S_MEPC: begin
            hold_o      = 1'b1;
            csr_wen_o   = 1'b1;
            csr_waddr_o = csr_addr(CSR_MEPC);
            csr_wdata_o = epc_q;
            state_nxt   = S_MCAUSE;
         end
         S_MCAUSE: begin
            hold_o      = 1'b1;
            csr_wen_o   = 1'b1;
            csr_waddr_o = csr_addr(CSR_MCAUSE);
            csr_wdata_o = cause_q;
            state_nxt   = S_MSTATUS;
         end
         S_MSTATUS: begin
            hold_o      = 1'b1;
            csr_wen_o   = 1'b1;
            csr_waddr_o = csr_addr(CSR_MSTATUS);
            csr_wdata_o = mstatus_enter(mstatus_q);
            state_nxt   = S_JUMP;
         end
         S_MRET: begin
            hold_o      = 1'b1;
            csr_wen_o   = 1'b1;
            csr_waddr_o = csr_addr(CSR_MSTATUS);
            csr_wdata_o = mstatus_return(mstatus_q);
            state_nxt   = S_JUMP;
         end
         S_JUMP: begin
            // mtvec/mepc are read live; hold_o keeps EX from changing them.
            hold_o       = 1'b1;
            int_assert_o = 1'b1;
            int_addr_o   = mret_q ? mepc_i : {mtvec_i[31:2], 2'b00};
            state_nxt    = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
